// File: rtl/musicbox_pkg.sv
// musicbox_pkg: shared sequencer state encoding and ROM note markers
package musicbox_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, NOTE, GAP, PAUSE} state_t;
    localparam logic [7:0] REST     = 8'h00;
    localparam logic [7:0] END_MARK = 8'hFF;
    function automatic logic is_running(input state_t s);
        return (s == FETCH) || (s == WAIT) || (s == NOTE) || (s == GAP);
    endfunction
endpackage

// File: rtl/step_timer.sv
// step_timer: loadable down-counter that stops at zero and holds while en is low
module step_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         RESET,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero
);
    logic [W-1:0] count_d, count_q;
    // load wins over decrement; the count never wraps below zero
    always_comb begin
        count_d = load ? load_val : (en && count_q != '0) ? count_q - W'(1) : count_q;
    end
    // count register
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) count_q <= '0;
        else       count_q <= count_d;
    end
    assign count = count_q;
    assign zero  = count_q == '0;
endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: steps the note ROM at a fixed tempo, gaps notes, handles pause/song change and mm:ss
module song_sequencer
    import musicbox_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned STEP_CYCLES = 2**27,
    parameter int unsigned GAP_CYCLES  = 2**22,
    parameter int          ADDR_W      = 6,
    parameter int          LOOP        = 1
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              play_tog,
    input  logic              song_sel,
    input  logic [7:0]        rom_note,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_bank,
    output logic [7:0]        fullnote,
    output logic              playing,
    output logic              als,
    output logic              song_end,
    output logic [5:0]        mins,
    output logic [5:0]        secs
);
    localparam int CNT_W = $clog2(STEP_CYCLES);
    localparam int PRE_W = $clog2(CLK_HZ + 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_AT    = CNT_W'(GAP_CYCLES);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_HZ - 1);
    localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);

    state_t state_d, state_q, resume_d, resume_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic bank_d, bank_q, playing_d, playing_q, als_d, als_q, end_d, end_q;
    logic [7:0] note_d, note_q, held_d, held_q;
    logic [5:0] mins_d, mins_q, secs_d, secs_q;
    logic cnt_load, cnt_en, cnt_zero, pre_load, pre_zero, clr_time, song_edge, running, tick;
    logic [CNT_W-1:0] cnt_val, cnt;
    logic [PRE_W-1:0] pre_val, pre_cnt;

    assign song_edge = song_sel != bank_q;
    assign running   = is_running(state_q);
    assign tick      = playing_q && pre_cnt == PRE_ONE;
    assign cnt_en    = (state_q == NOTE || state_q == GAP) && !play_tog && !song_edge;
    assign pre_load  = clr_time || (playing_q && pre_zero);
    assign pre_val   = clr_time ? '0 : PRE_LAST;

    step_timer #(.W(CNT_W)) u_step (
        .clk(clk), .RESET(RESET), .load(cnt_load), .load_val(cnt_val),
        .en(cnt_en), .count(cnt), .zero(cnt_zero)
    );

    step_timer #(.W(PRE_W)) u_prescale (
        .clk(clk), .RESET(RESET), .load(pre_load), .load_val(pre_val),
        .en(playing_q), .count(pre_cnt), .zero(pre_zero)
    );

    // playback FSM: song edge first, then play toggle, otherwise normal stepping
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        addr_d   = addr_q;
        bank_d   = bank_q;
        note_d   = note_q;
        held_d   = held_q;
        end_d    = 1'b0;
        clr_time = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        if (song_edge) begin
            bank_d   = song_sel;
            addr_d   = '0;
            cnt_load = 1'b1;
            clr_time = 1'b1;
            note_d   = REST;
            state_d  = running ? FETCH : state_q;
            resume_d = running ? resume_q : FETCH;
        end
        if (play_tog) begin
            if (state_d == IDLE) begin
                state_d = FETCH;
            end else if (state_d == PAUSE) begin
                state_d = resume_d;
                note_d  = (resume_d == NOTE) ? held_q : REST;
            end else begin
                resume_d = state_d;
                state_d  = PAUSE;
                note_d   = REST;
            end
        end else if (!song_edge) begin
            case (state_q)
                FETCH: state_d = WAIT;
                WAIT: begin
                    if (rom_note == END_MARK) begin
                        end_d    = 1'b1;
                        addr_d   = '0;
                        state_d  = (LOOP != 0) ? FETCH : IDLE;
                        clr_time = (LOOP == 0);
                    end else begin
                        note_d   = rom_note;
                        held_d   = rom_note;
                        cnt_load = 1'b1;
                        cnt_val  = STEP_LAST;
                        state_d  = NOTE;
                    end
                end
                NOTE: begin
                    if (cnt == GAP_AT) begin
                        note_d  = REST;
                        state_d = GAP;
                    end
                end
                GAP: begin
                    if (cnt_zero) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    // elapsed mm:ss, cleared on song change or end of a non-looping song; minutes saturate
    always_comb begin
        mins_d    = mins_q;
        secs_d    = secs_q;
        playing_d = is_running(state_d);
        als_d     = !playing_d;
        if (clr_time) begin
            mins_d = '0;
            secs_d = '0;
        end else if (tick) begin
            secs_d = (secs_q == 6'd59) ? 6'd0 : secs_q + 6'd1;
            mins_d = (secs_q == 6'd59 && mins_q != 6'd59) ? mins_q + 6'd1 : mins_q;
        end
    end

    // all state and outputs are registered; bank resets to the current switch position
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            resume_q  <= IDLE;
            addr_q    <= '0;
            bank_q    <= song_sel;
            note_q    <= REST;
            held_q    <= REST;
            playing_q <= 1'b0;
            als_q     <= 1'b1;
            end_q     <= 1'b0;
            mins_q    <= '0;
            secs_q    <= '0;
        end else begin
            state_q   <= state_d;
            resume_q  <= resume_d;
            addr_q    <= addr_d;
            bank_q    <= bank_d;
            note_q    <= note_d;
            held_q    <= held_d;
            playing_q <= playing_d;
            als_q     <= als_d;
            end_q     <= end_d;
            mins_q    <= mins_d;
            secs_q    <= secs_d;
        end
    end

    assign rom_addr = addr_q;
    assign rom_bank = bank_q;
    assign fullnote = note_q;
    assign playing  = playing_q;
    assign als      = als_q;
    assign song_end = end_q;
    assign mins     = mins_q;
    assign secs     = secs_q;
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed table and sequence checks of the song sequencer
module tb_song_sequencer;
    logic clk, RESET, tog, tog0, tog_s, sel;
    logic [7:0] mem [0:127];
    logic [7:0] rn_m, rn_0, rn_s, full_m, full_0, full_s;
    logic [5:0] addr_m, addr_0, addr_s, mins_m, mins_0, mins_s, secs_m, secs_0, secs_s;
    logic bank_m, bank_0, bank_s, play_m, play_0, play_s, als_m, als_0, als_s, se_m, se_0, se_s;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       tog;
        int         reps;
        logic [5:0] addr;
        logic [7:0] note;
        logic       play;
        logic       se;
    } vec_t;
    vec_t vt [14];

    song_sequencer #(.CLK_HZ(32), .STEP_CYCLES(16), .GAP_CYCLES(4), .ADDR_W(6), .LOOP(1)) dut (
        .clk(clk), .RESET(RESET), .play_tog(tog), .song_sel(sel), .rom_note(rn_m),
        .rom_addr(addr_m), .rom_bank(bank_m), .fullnote(full_m), .playing(play_m),
        .als(als_m), .song_end(se_m), .mins(mins_m), .secs(secs_m)
    );

    song_sequencer #(.CLK_HZ(32), .STEP_CYCLES(16), .GAP_CYCLES(4), .ADDR_W(6), .LOOP(0)) dut0 (
        .clk(clk), .RESET(RESET), .play_tog(tog0), .song_sel(1'b0), .rom_note(rn_0),
        .rom_addr(addr_0), .rom_bank(bank_0), .fullnote(full_0), .playing(play_0),
        .als(als_0), .song_end(se_0), .mins(mins_0), .secs(secs_0)
    );

    song_sequencer #(.CLK_HZ(2), .STEP_CYCLES(16), .GAP_CYCLES(4), .ADDR_W(6), .LOOP(1)) dut_sat (
        .clk(clk), .RESET(RESET), .play_tog(tog_s), .song_sel(1'b1), .rom_note(rn_s),
        .rom_addr(addr_s), .rom_bank(bank_s), .fullnote(full_s), .playing(play_s),
        .als(als_s), .song_end(se_s), .mins(mins_s), .secs(secs_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rn_m <= mem[{bank_m, addr_m}];
        rn_0 <= mem[{bank_0, addr_0}];
        rn_s <= mem[{bank_s, addr_s}];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        vt[0]  = '{1'b1, 1,  6'd0, 8'h00, 1'b1, 1'b0};
        vt[1]  = '{1'b0, 1,  6'd0, 8'h00, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 12, 6'd0, 8'h11, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 4,  6'd0, 8'h00, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 2,  6'd1, 8'h00, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 12, 6'd1, 8'h22, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 4,  6'd1, 8'h00, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 2,  6'd2, 8'h00, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 12, 6'd2, 8'h33, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 4,  6'd2, 8'h00, 1'b1, 1'b0};
        vt[10] = '{1'b0, 2,  6'd3, 8'h00, 1'b1, 1'b0};
        vt[11] = '{1'b0, 1,  6'd0, 8'h00, 1'b1, 1'b1};
        vt[12] = '{1'b0, 1,  6'd0, 8'h00, 1'b1, 1'b0};
        vt[13] = '{1'b0, 3,  6'd0, 8'h11, 1'b1, 1'b0};
        for (int i = 0; i < 64; i++) begin
            mem[i]      = 8'h40 + 8'(i);
            mem[64 + i] = 8'hA0 + 8'(i);
        end
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        mem[3] = 8'hFF;
        RESET = 1'b1; tog = 1'b0; tog0 = 1'b0; tog_s = 1'b0; sel = 1'b0;
        repeat (2) @(posedge clk);
        #2 RESET = 1'b0;
        #1;
        chk("rst_addr", 0, 32'(addr_m), 0);
        chk("rst_note", 0, 32'(full_m), 0);
        chk("rst_play", 0, 32'(play_m), 0);
        chk("rst_als", 0, 32'(als_m), 1);
        chk("rst_end", 0, 32'(se_m), 0);
        chk("rst_bank", 0, 32'(bank_m), 0);
        chk("rst_time", 0, 32'({mins_m, secs_m}), 0);
        // first pass through the song, loop back at END_MARK
        for (int i = 0; i < 14; i++) begin
            for (int r = 0; r < vt[i].reps; r++) begin
                tog = (r == 0) ? vt[i].tog : 1'b0;
                step();
                chk("t1_addr", i, 32'(addr_m), 32'(vt[i].addr));
                chk("t1_note", i, 32'(full_m), 32'(vt[i].note));
                chk("t1_play", i, 32'(play_m), 32'(vt[i].play));
                chk("t1_als", i, 32'(als_m), 32'(!vt[i].play));
                chk("t1_end", i, 32'(se_m), 32'(vt[i].se));
            end
        end
        tog = 1'b0;
        // pause with the step counter at 9, hold 50 cycles, resume
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_pre", i, 32'(full_m), 32'h11);
        end
        tog = 1'b1; step(); tog = 1'b0;
        chk("t2_pause_note", 0, 32'(full_m), 0);
        chk("t2_pause_play", 0, 32'(play_m), 0);
        chk("t2_pause_als", 0, 32'(als_m), 1);
        chk("t2_pause_secs", 0, 32'(secs_m), 2);
        repeat (50) step();
        chk("t2_hold_note", 0, 32'(full_m), 0);
        chk("t2_hold_secs", 0, 32'(secs_m), 2);
        tog = 1'b1; step(); tog = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            chk("t2_resume", i, 32'(full_m), (i < 6) ? 32'h11 : 32'h0);
        end
        step();
        chk("t2_next_addr", 0, 32'(addr_m), 1);
        // song change during GAP, then in PAUSE, then together with a toggle
        repeat (14) step();
        chk("t4_gap_addr", 0, 32'(addr_m), 1);
        chk("t4_gap_note", 0, 32'(full_m), 0);
        sel = 1'b1; step();
        chk("t4_bank", 0, 32'(bank_m), 1);
        chk("t4_addr", 0, 32'(addr_m), 0);
        chk("t4_play", 0, 32'(play_m), 1);
        chk("t4_time", 0, 32'({mins_m, secs_m}), 0);
        repeat (2) step();
        chk("t4_note", 0, 32'(full_m), 32'hA0);
        repeat (16) step();
        chk("t4_addr1", 0, 32'(addr_m), 1);
        tog = 1'b1; step(); tog = 1'b0;
        chk("t4_pause", 0, 32'(play_m), 0);
        sel = 1'b0; step();
        chk("t4_p_play", 0, 32'(play_m), 0);
        chk("t4_p_bank", 0, 32'(bank_m), 0);
        chk("t4_p_addr", 0, 32'(addr_m), 0);
        step();
        chk("t4_p_stay", 0, 32'(play_m), 0);
        tog = 1'b1; step(); tog = 1'b0;
        chk("t4_p_resume", 0, 32'(play_m), 1);
        chk("t4_p_raddr", 0, 32'(addr_m), 0);
        repeat (18) step();
        chk("t4_addr1b", 0, 32'(addr_m), 1);
        tog = 1'b1; step(); tog = 1'b0;
        chk("t4_pause2", 0, 32'(play_m), 0);
        sel = 1'b1; tog = 1'b1; step(); tog = 1'b0;
        chk("t4_both_play", 0, 32'(play_m), 1);
        chk("t4_both_addr", 0, 32'(addr_m), 0);
        chk("t4_both_bank", 0, 32'(bank_m), 1);
        // asynchronous reset in the middle of a note
        repeat (2) step();
        chk("t5_note", 0, 32'(full_m), 32'hA0);
        #1 RESET = 1'b1;
        #1;
        chk("t5_note0", 0, 32'(full_m), 0);
        chk("t5_als", 0, 32'(als_m), 1);
        chk("t5_addr", 0, 32'(addr_m), 0);
        chk("t5_play", 0, 32'(play_m), 0);
        chk("t5_bank", 0, 32'(bank_m), 1);
        @(posedge clk);
        #2 RESET = 1'b0;
        step();
        chk("t5_idle", 0, 32'(play_m), 0);
        // elapsed time over 61 seconds of continuous play
        tog = 1'b1; step(); tog = 1'b0;
        for (int n = 1; n <= 1952; n++) begin
            step();
            if (n == 31)   chk("t6_31", n, 32'({mins_m, secs_m}), {6'd0, 6'd0});
            if (n == 32)   chk("t6_32", n, 32'({mins_m, secs_m}), {6'd0, 6'd1});
            if (n == 1919) chk("t6_1919", n, 32'({mins_m, secs_m}), {6'd0, 6'd59});
            if (n == 1920) chk("t6_1920", n, 32'({mins_m, secs_m}), {6'd1, 6'd0});
            if (n == 1952) chk("t6_1952", n, 32'({mins_m, secs_m}), {6'd1, 6'd1});
        end
        // non-looping song stops in IDLE with time cleared
        begin
            int pulses = 0;
            tog0 = 1'b1; step(); tog0 = 1'b0;
            for (int n = 1; n <= 60; n++) begin
                step();
                if (se_0) pulses++;
                if (n == 55) chk("t3_pre_secs", n, 32'(secs_0), 1);
                if (n == 56) begin
                    chk("t3_end", n, 32'(se_0), 1);
                    chk("t3_play", n, 32'(play_0), 0);
                    chk("t3_als", n, 32'(als_0), 1);
                    chk("t3_addr", n, 32'(addr_0), 0);
                    chk("t3_time", n, 32'({mins_0, secs_0}), 0);
                end
                if (n == 58) chk("t3_idle", n, 32'(play_0), 0);
            end
            chk("t3_pulses", 0, 32'(pulses), 1);
        end
        // minutes saturate at 59; address wraps past 63 without END_MARK
        tog_s = 1'b1; step(); tog_s = 1'b0;
        for (int n = 1; n <= 7202; n++) begin
            step();
            if (n == 1151) chk("ts_addr63", n, 32'(addr_s), 63);
            if (n == 1152) chk("ts_wrap", n, 32'({play_s, addr_s}), {1'b1, 6'd0});
            if (n == 1154) chk("ts_wrap_note", n, 32'(full_s), 32'hA0);
            if (n == 7197) chk("ts_5958", n, 32'({mins_s, secs_s}), {6'd59, 6'd58});
            if (n == 7198) chk("ts_5959", n, 32'({mins_s, secs_s}), {6'd59, 6'd59});
            if (n == 7200) chk("ts_sat0", n, 32'({mins_s, secs_s}), {6'd59, 6'd0});
            if (n == 7202) chk("ts_sat1", n, 32'({mins_s, secs_s}), {6'd59, 6'd1});
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
